// File: rtl/fetch_unit_pkg.sv
// Shared widths and encodings for the fetch stage and the instruction memory model.
package fetch_unit_pkg;
    localparam int ADDR_W      = 32;
    localparam int INSTR_W     = 32;
    localparam int INSTR_BYTES = 4;

    // addi x0, x0, 0
    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_unit_hold_buffer.sv
// One-entry skid for the fetched word plus the decode-facing instruction mux.
module fetch_hold_buffer
    import fetch_unit_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_redirect,
    input  logic               i_advance,
    input  logic               i_resp_valid,
    input  logic [INSTR_W-1:0] i_res_data,
    output logic [INSTR_W-1:0] o_instr
);
    logic               r_hold_valid;
    logic [INSTR_W-1:0] r_hold_instr;
    logic [INSTR_W-1:0] w_src;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_valid <= 1'b0;
            r_hold_instr <= NOP;
        end else if (i_redirect || i_advance) begin
            r_hold_valid <= 1'b0;
        end else if (!r_hold_valid) begin
            // Memory keeps re-reading the next PC while stalled, so capture now.
            r_hold_instr <= i_res_data;
            r_hold_valid <= 1'b1;
        end
    end

    always_comb begin
        w_src   = r_hold_valid ? r_hold_instr : i_res_data;
        o_instr = i_resp_valid ? w_src : NOP;
    end
endmodule

// File: rtl/fetch_unit.sv
// PC register and fetch stage: drives the 1-cycle instruction memory and pairs data with its PC.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_stall,
    input  logic               i_redirect,
    input  logic [ADDR_W-1:0]  i_redirect_addr,
    output logic [ADDR_W-1:0]  o_req_addr,
    input  logic [INSTR_W-1:0] i_res_data,
    output logic               o_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [ADDR_W-1:0]  o_pc
);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INSTR_BYTES);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_resp_pc;
    logic              r_resp_valid;
    logic              w_advance;

    assign w_advance = !(r_resp_valid && i_stall);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= RESET_PC[ADDR_W-1:0];
            r_resp_pc    <= '0;
            r_resp_valid <= 1'b0;
        end else if (i_redirect) begin
            // Whatever the memory returns next belongs to the old path.
            r_pc         <= word_align(i_redirect_addr);
            r_resp_valid <= 1'b0;
        end else if (w_advance) begin
            r_resp_pc    <= r_pc;
            r_resp_valid <= 1'b1;
            r_pc         <= r_pc + PC_STEP;
        end
    end

    fetch_hold_buffer u_hold (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_redirect   (i_redirect),
        .i_advance    (w_advance),
        .i_resp_valid (r_resp_valid),
        .i_res_data   (i_res_data),
        .o_instr      (o_instr)
    );

    assign o_req_addr = r_pc;
    assign o_valid    = r_resp_valid;
    assign o_pc       = r_resp_pc;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a synchronous 1-cycle instruction memory model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic               clk;
    logic               rst_n;
    logic               i_stall;
    logic               i_redirect;
    logic [ADDR_W-1:0]  i_redirect_addr;
    logic [ADDR_W-1:0]  o_req_addr;
    logic [INSTR_W-1:0] i_res_data;
    logic               o_valid;
    logic [INSTR_W-1:0] o_instr;
    logic [ADDR_W-1:0]  o_pc;

    int errors = 0;
    int checks = 0;

    fetch_unit #(.RESET_PC(32'h0)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_stall         (i_stall),
        .i_redirect      (i_redirect),
        .i_redirect_addr (i_redirect_addr),
        .o_req_addr      (o_req_addr),
        .i_res_data      (i_res_data),
        .o_valid         (o_valid),
        .o_instr         (o_instr),
        .o_pc            (o_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory word k holds 0x13+k; 64 words, address bits [7:2] index it.
    always @(posedge clk) i_res_data <= 32'h13 + 32'(o_req_addr[7:2]);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_stall = 1'b0; i_redirect = 1'b0; i_redirect_addr = '0;
        tick(); tick();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", o_valid); end
        checks++; if (o_instr !== NOP) begin errors++; $display("FAIL reset_instr got=%h exp=%h", o_instr, NOP); end
        checks++; if (o_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", o_pc); end
        checks++; if (o_req_addr !== 32'h0) begin errors++; $display("FAIL reset_req got=%h exp=0", o_req_addr); end
        // Redirect while held in reset must not move the PC.
        i_redirect = 1'b1; i_redirect_addr = 32'h40;
        tick();
        checks++; if (o_req_addr !== 32'h0) begin errors++; $display("FAIL reset_redirect_req got=%h exp=0", o_req_addr); end
        i_redirect = 1'b0;
        rst_n = 1'b1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL release_valid got=%0b exp=0", o_valid); end
    endtask

    task automatic test_stream();
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL stream_valid k=%0d got=%0b exp=1", k, o_valid); end
            checks++; if (o_pc !== 32'(4*k)) begin errors++; $display("FAIL stream_pc k=%0d got=%h exp=%h", k, o_pc, 4*k); end
            checks++; if (o_instr !== 32'(32'h13 + k)) begin errors++; $display("FAIL stream_instr k=%0d got=%h exp=%h", k, o_instr, 32'h13 + k); end
        end
    endtask

    // Entered with o_pc=8 on display.
    task automatic test_stall();
        i_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (o_valid !== 1'b1 || o_pc !== 32'h8) begin errors++; $display("FAIL stall_pc k=%0d got=%0b/%h exp=1/8", k, o_valid, o_pc); end
            checks++; if (o_instr !== 32'h15) begin errors++; $display("FAIL stall_instr k=%0d got=%h exp=15", k, o_instr); end
        end
        i_stall = 1'b0;
        tick();
        checks++; if (o_valid !== 1'b1 || o_pc !== 32'hC || o_instr !== 32'h16) begin errors++; $display("FAIL stall_release1 got=%0b/%h/%h exp=1/c/16", o_valid, o_pc, o_instr); end
        tick();
        checks++; if (o_valid !== 1'b1 || o_pc !== 32'h10 || o_instr !== 32'h17) begin errors++; $display("FAIL stall_release2 got=%0b/%h/%h exp=1/10/17", o_valid, o_pc, o_instr); end
    endtask

    task automatic test_redirect();
        i_redirect = 1'b1; i_redirect_addr = 32'h20;
        tick();
        i_redirect = 1'b0;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL redir_bubble_valid got=%0b exp=0", o_valid); end
        checks++; if (o_instr !== NOP) begin errors++; $display("FAIL redir_bubble_instr got=%h exp=%h", o_instr, NOP); end
        checks++; if (o_req_addr !== 32'h20) begin errors++; $display("FAIL redir_req got=%h exp=20", o_req_addr); end
        tick();
        checks++; if (o_valid !== 1'b1 || o_pc !== 32'h20 || o_instr !== 32'h1B) begin errors++; $display("FAIL redir_target got=%0b/%h/%h exp=1/20/1b", o_valid, o_pc, o_instr); end
        tick();
        checks++; if (o_valid !== 1'b1 || o_pc !== 32'h24 || o_instr !== 32'h1C) begin errors++; $display("FAIL redir_next got=%0b/%h/%h exp=1/24/1c", o_valid, o_pc, o_instr); end
    endtask

    // Entered with o_pc=0x24 on display; fill the hold, then redirect under stall.
    task automatic test_redirect_stall();
        i_stall = 1'b1;
        tick(); tick();
        checks++; if (o_pc !== 32'h24 || o_instr !== 32'h1C) begin errors++; $display("FAIL rs_held got=%h/%h exp=24/1c", o_pc, o_instr); end
        i_redirect = 1'b1; i_redirect_addr = 32'h20;
        tick();
        i_redirect = 1'b0; i_stall = 1'b0;
        checks++; if (o_valid !== 1'b0 || o_instr !== NOP || o_req_addr !== 32'h20) begin errors++; $display("FAIL rs_bubble got=%0b/%h/%h exp=0/%h/20", o_valid, o_instr, o_req_addr, NOP); end
        tick();
        checks++; if (o_valid !== 1'b1 || o_pc !== 32'h20 || o_instr !== 32'h1B) begin errors++; $display("FAIL rs_target got=%0b/%h/%h exp=1/20/1b", o_valid, o_pc, o_instr); end
        tick();
        checks++; if (o_pc !== 32'h24 || o_instr !== 32'h1C) begin errors++; $display("FAIL rs_next got=%h/%h exp=24/1c", o_pc, o_instr); end
    endtask

    task automatic test_unaligned();
        i_redirect = 1'b1; i_redirect_addr = 32'h23;
        tick();
        i_redirect = 1'b0;
        checks++; if (o_req_addr !== 32'h20) begin errors++; $display("FAIL unalign_req got=%h exp=20", o_req_addr); end
        tick();
        checks++; if (o_valid !== 1'b1 || o_pc !== 32'h20 || o_instr !== 32'h1B) begin errors++; $display("FAIL unalign_pc got=%0b/%h/%h exp=1/20/1b", o_valid, o_pc, o_instr); end
    endtask

    task automatic test_async_reset();
        i_stall = 1'b1;
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (o_valid !== 1'b0 || o_instr !== NOP) begin errors++; $display("FAIL areset_valid got=%0b/%h exp=0/%h", o_valid, o_instr, NOP); end
        checks++; if (o_req_addr !== 32'h0 || o_pc !== 32'h0) begin errors++; $display("FAIL areset_req got=%h/%h exp=0/0", o_req_addr, o_pc); end
        tick();
        i_stall = 1'b0;
        rst_n = 1'b1;
        tick();
        checks++; if (o_valid !== 1'b1 || o_pc !== 32'h0 || o_instr !== 32'h13) begin errors++; $display("FAIL areset_resume0 got=%0b/%h/%h exp=1/0/13", o_valid, o_pc, o_instr); end
        tick();
        checks++; if (o_pc !== 32'h4 || o_instr !== 32'h14) begin errors++; $display("FAIL areset_resume1 got=%h/%h exp=4/14", o_pc, o_instr); end
    endtask

    task automatic test_wrap();
        i_redirect = 1'b1; i_redirect_addr = 32'hFFFF_FFFC;
        tick();
        i_redirect = 1'b0;
        tick();
        checks++; if (o_valid !== 1'b1 || o_pc !== 32'hFFFF_FFFC || o_instr !== 32'h52) begin errors++; $display("FAIL wrap_top got=%0b/%h/%h exp=1/fffffffc/52", o_valid, o_pc, o_instr); end
        tick();
        checks++; if (o_valid !== 1'b1 || o_pc !== 32'h0 || o_instr !== 32'h13) begin errors++; $display("FAIL wrap_zero got=%0b/%h/%h exp=1/0/13", o_valid, o_pc, o_instr); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_unaligned();
        test_async_reset();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
